// File: rtl/axil_arbiter_2x1_if.sv
// axil_if: AXI4-Lite bundle shared by the arbiter's requester and downstream ports.
//   Parameters: DW (data width), AW (address width); wstrb is DW/8 bits.
//   modport s_axil: slave side (sees requests, drives ready/response).
//   modport m_axil: master side (drives requests, sees ready/response).
// Handshake rule on every channel: a beat transfers on the rising clock edge
// where valid and ready are both 1; valid is held until that edge.
interface axil_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport s_axil (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m_axil (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arbiter_2x1.sv
// axil_arbiter_2x1: shares one downstream AXI-Lite slave between two requesters.
// Independent write (AW/W/B) and read (AR/R) arbiters; each holds its grant from
// address phase until the response handshake.
// Ports:
//   aclk, aresetn   clock (rising edge) and asynchronous active-low reset
//   s0_axil         requester 0 (slave side)
//   s1_axil         requester 1 (slave side)
//   m_axil          shared downstream slave (master side)
//   o_wr_state      write FSM state (0 idle, 1 addr, 2 resp) for observation
//   o_rd_state      read FSM state (0 idle, 1 addr, 2 resp) for observation
// Build option: define AXIL_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// ties, no last-grant pointers); otherwise round-robin on ties.
// Handshake: a beat transfers when valid & ready are both 1 at a rising edge.
module axil_arbiter_2x1 #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic       aclk,
  input  logic       aresetn,
  axil_if.s_axil     s0_axil,
  axil_if.s_axil     s1_axil,
  axil_if.m_axil     m_axil,
  output logic [1:0] o_wr_state,
  output logic [1:0] o_rd_state
);
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_RESP = 2'd2} rd_state_t;

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;
  logic r_wr_gnt, r_rd_gnt, r_aw_done, r_w_done;
  logic w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1, w_wr_pick, w_rd_pick;

  // Granted-port views of the request-side inputs
  logic                        w_sel_awvalid, w_sel_wvalid, w_sel_bready;
  logic                        w_sel_arvalid, w_sel_rready;
  logic [AXI_ADDR_WIDTH-1:0]   w_sel_awaddr, w_sel_araddr;
  logic [AXI_DATA_WIDTH-1:0]   w_sel_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] w_sel_wstrb;
  logic w_fwd_awvalid, w_fwd_wvalid, w_fwd_arvalid;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_wr_req0 = s0_axil.awvalid & s0_axil.wvalid;
  assign w_wr_req1 = s1_axil.awvalid & s1_axil.wvalid;
  assign w_rd_req0 = s0_axil.arvalid;
  assign w_rd_req1 = s1_axil.arvalid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  // Port 1 only when port 0 is not asking
  assign w_wr_pick = ~w_wr_req0;
  assign w_rd_pick = ~w_rd_req0;
`else
  logic r_wr_last, r_rd_last;
  // On a tie, the port not served last on this channel wins
  assign w_wr_pick = (w_wr_req0 & w_wr_req1) ? ~r_wr_last : w_wr_req1;
  assign w_rd_pick = (w_rd_req0 & w_rd_req1) ? ~r_rd_last : w_rd_req1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_last <= 1'b1;
      r_rd_last <= 1'b1;
    end else begin
      if (w_b_hs) r_wr_last <= r_wr_gnt;
      if (w_r_hs) r_rd_last <= r_rd_gnt;
    end
  end
`endif

  assign w_sel_awvalid = r_wr_gnt ? s1_axil.awvalid : s0_axil.awvalid;
  assign w_sel_awaddr  = r_wr_gnt ? s1_axil.awaddr  : s0_axil.awaddr;
  assign w_sel_wvalid  = r_wr_gnt ? s1_axil.wvalid  : s0_axil.wvalid;
  assign w_sel_wdata   = r_wr_gnt ? s1_axil.wdata   : s0_axil.wdata;
  assign w_sel_wstrb   = r_wr_gnt ? s1_axil.wstrb   : s0_axil.wstrb;
  assign w_sel_bready  = r_wr_gnt ? s1_axil.bready  : s0_axil.bready;
  assign w_sel_arvalid = r_rd_gnt ? s1_axil.arvalid : s0_axil.arvalid;
  assign w_sel_araddr  = r_rd_gnt ? s1_axil.araddr  : s0_axil.araddr;
  assign w_sel_rready  = r_rd_gnt ? s1_axil.rready  : s0_axil.rready;

  // A channel that already handshook stops forwarding its valid
  assign w_fwd_awvalid = (r_wr_state == WR_ADDR) & w_sel_awvalid & ~r_aw_done;
  assign w_fwd_wvalid  = (r_wr_state == WR_ADDR) & w_sel_wvalid  & ~r_w_done;
  assign w_fwd_arvalid = (r_rd_state == RD_ADDR) & w_sel_arvalid;
  assign w_aw_hs = w_fwd_awvalid & m_axil.awready;
  assign w_w_hs  = w_fwd_wvalid  & m_axil.wready;
  assign w_ar_hs = w_fwd_arvalid & m_axil.arready;
  assign w_b_hs  = (r_wr_state == WR_RESP) & m_axil.bvalid & w_sel_bready;
  assign w_r_hs  = (r_rd_state == RD_RESP) & m_axil.rvalid & w_sel_rready;

  assign o_wr_state = r_wr_state;
  assign o_rd_state = r_rd_state;

  // ---------------- write arbiter ----------------
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_wr_req0 | w_wr_req1) w_wr_next = WR_ADDR;
      WR_ADDR: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_wr_next = WR_RESP;
      WR_RESP: if (w_b_hs) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= WR_IDLE;
      r_wr_gnt   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      if (r_wr_state == WR_IDLE && (w_wr_req0 | w_wr_req1)) r_wr_gnt <= w_wr_pick;
      if (r_wr_state == WR_ADDR && w_wr_next == WR_ADDR) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    m_axil.awvalid  = w_fwd_awvalid;
    m_axil.wvalid   = w_fwd_wvalid;
    m_axil.awaddr   = '0;
    m_axil.wdata    = '0;
    m_axil.wstrb    = '0;
    m_axil.bready   = 1'b0;
    s0_axil.awready = 1'b0;
    s0_axil.wready  = 1'b0;
    s0_axil.bvalid  = 1'b0;
    s0_axil.bresp   = '0;
    s1_axil.awready = 1'b0;
    s1_axil.wready  = 1'b0;
    s1_axil.bvalid  = 1'b0;
    s1_axil.bresp   = '0;
    if (r_wr_state == WR_ADDR) begin
      m_axil.awaddr = w_sel_awaddr;
      m_axil.wdata  = w_sel_wdata;
      m_axil.wstrb  = w_sel_wstrb;
      if (r_wr_gnt) begin
        s1_axil.awready = m_axil.awready & ~r_aw_done;
        s1_axil.wready  = m_axil.wready  & ~r_w_done;
      end else begin
        s0_axil.awready = m_axil.awready & ~r_aw_done;
        s0_axil.wready  = m_axil.wready  & ~r_w_done;
      end
    end else if (r_wr_state == WR_RESP) begin
      m_axil.bready = w_sel_bready;
      if (r_wr_gnt) begin
        s1_axil.bvalid = m_axil.bvalid;
        s1_axil.bresp  = m_axil.bresp;
      end else begin
        s0_axil.bvalid = m_axil.bvalid;
        s0_axil.bresp  = m_axil.bresp;
      end
    end
  end

  // ---------------- read arbiter ----------------
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_rd_req0 | w_rd_req1) w_rd_next = RD_ADDR;
      RD_ADDR: if (w_ar_hs) w_rd_next = RD_RESP;
      RD_RESP: if (w_r_hs) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state <= RD_IDLE;
      r_rd_gnt   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == RD_IDLE && (w_rd_req0 | w_rd_req1)) r_rd_gnt <= w_rd_pick;
    end
  end

  always_comb begin
    m_axil.arvalid  = w_fwd_arvalid;
    m_axil.araddr   = '0;
    m_axil.rready   = 1'b0;
    s0_axil.arready = 1'b0;
    s0_axil.rvalid  = 1'b0;
    s0_axil.rdata   = '0;
    s0_axil.rresp   = '0;
    s1_axil.arready = 1'b0;
    s1_axil.rvalid  = 1'b0;
    s1_axil.rdata   = '0;
    s1_axil.rresp   = '0;
    if (r_rd_state == RD_ADDR) begin
      m_axil.araddr = w_sel_araddr;
      if (r_rd_gnt) s1_axil.arready = m_axil.arready;
      else          s0_axil.arready = m_axil.arready;
    end else if (r_rd_state == RD_RESP) begin
      m_axil.rready = w_sel_rready;
      if (r_rd_gnt) begin
        s1_axil.rvalid = m_axil.rvalid;
        s1_axil.rdata  = m_axil.rdata;
        s1_axil.rresp  = m_axil.rresp;
      end else begin
        s0_axil.rvalid = m_axil.rvalid;
        s0_axil.rdata  = m_axil.rdata;
        s0_axil.rresp  = m_axil.rresp;
      end
    end
  end
endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Testbench for axil_arbiter_2x1: two requester drivers, a register-file slave
// model with adjustable ready delays, a word-level memory reference model and
// an expected-order queue for downstream write data.
module tb_axil_arbiter_2x1;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 300;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_if #(.DW(DW), .AW(AW)) s0 ();
  axil_if #(.DW(DW), .AW(AW)) s1 ();
  axil_if #(.DW(DW), .AW(AW)) m ();
  logic [1:0] wr_st, rd_st;

  axil_arbiter_2x1 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .s0_axil(s0), .s1_axil(s1), .m_axil(m),
    .o_wr_state(wr_st), .o_rd_state(rd_st)
  );

  // requester-side drive, indexed by port
  logic          q_awvalid[2], q_wvalid[2], q_bready[2], q_arvalid[2], q_rready[2];
  logic [AW-1:0] q_awaddr[2], q_araddr[2];
  logic [DW-1:0] q_wdata[2];
  assign s0.awvalid = q_awvalid[0]; assign s1.awvalid = q_awvalid[1];
  assign s0.awaddr  = q_awaddr[0];  assign s1.awaddr  = q_awaddr[1];
  assign s0.wvalid  = q_wvalid[0];  assign s1.wvalid  = q_wvalid[1];
  assign s0.wdata   = q_wdata[0];   assign s1.wdata   = q_wdata[1];
  assign s0.wstrb   = 4'hF;         assign s1.wstrb   = 4'hF;
  assign s0.bready  = q_bready[0];  assign s1.bready  = q_bready[1];
  assign s0.arvalid = q_arvalid[0]; assign s1.arvalid = q_arvalid[1];
  assign s0.araddr  = q_araddr[0];  assign s1.araddr  = q_araddr[1];
  assign s0.rready  = q_rready[0];  assign s1.rready  = q_rready[1];

  wire [1:0] p_awready = {s1.awready, s0.awready};
  wire [1:0] p_wready  = {s1.wready,  s0.wready};
  wire [1:0] p_bvalid  = {s1.bvalid,  s0.bvalid};
  wire [1:0] p_arready = {s1.arready, s0.arready};
  wire [1:0] p_rvalid  = {s1.rvalid,  s0.rvalid};
  logic [1:0]    p_bresp[2];
  logic [1:0]    p_rresp[2];
  logic [DW-1:0] p_rdata[2];
  assign p_bresp[0] = s0.bresp; assign p_bresp[1] = s1.bresp;
  assign p_rresp[0] = s0.rresp; assign p_rresp[1] = s1.rresp;
  assign p_rdata[0] = s0.rdata; assign p_rdata[1] = s1.rdata;

  // ---------------- downstream slave model ----------------
  logic [DW-1:0] mem[16];
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got;
  logic [3:0] aw_idx;
  logic [DW-1:0] w_data;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m.awready <= 0; m.wready <= 0; m.bvalid <= 0; m.bresp <= 0;
      m.arready <= 0; m.rvalid <= 0; m.rdata <= 0; m.rresp <= 0;
      aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (m.awvalid && m.awready) begin
        m.awready <= 0; aw_got <= 1; aw_idx <= m.awaddr[5:2]; aw_cnt <= 0;
      end else if (m.awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) m.awready <= 1; else aw_cnt <= aw_cnt + 1;
      end
      if (m.wvalid && m.wready) begin
        m.wready <= 0; w_got <= 1; w_data <= m.wdata; w_cnt <= 0;
      end else if (m.wvalid && !w_got) begin
        if (w_cnt >= w_dly) m.wready <= 1; else w_cnt <= w_cnt + 1;
      end
      if (m.bvalid) begin
        if (m.bready) begin m.bvalid <= 0; aw_got <= 0; w_got <= 0; end
      end else if (aw_got && w_got) begin
        mem[aw_idx] <= w_data; m.bvalid <= 1; m.bresp <= 2'b00;
      end
      if (m.rvalid) begin
        if (m.rready) m.rvalid <= 0;
      end else if (m.arvalid && m.arready) begin
        m.arready <= 0; m.rvalid <= 1; m.rdata <= mem[m.araddr[5:2]]; m.rresp <= 2'b00; ar_cnt <= 0;
      end else if (m.arvalid) begin
        if (ar_cnt >= ar_dly) m.arready <= 1; else ar_cnt <= ar_cnt + 1;
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, m_aw_n = 0, m_w_n = 0, inv_err = 0;
  int b_n[2], b_cyc[2], aw_cyc[2];
  logic [DW-1:0] w_order[$];

  initial begin
    b_n[0] = 0; b_n[1] = 0; b_cyc[0] = 0; b_cyc[1] = 0; aw_cyc[0] = 0; aw_cyc[1] = 0;
  end

  always @(negedge aclk) begin
    cyc <= cyc + 1;
    if (aresetn) begin
      if (m.awvalid && m.awready) m_aw_n <= m_aw_n + 1;
      if (m.wvalid && m.wready) begin m_w_n <= m_w_n + 1; w_order.push_back(m.wdata); end
      for (int p = 0; p < 2; p++) begin
        if (p_bvalid[p] && q_bready[p]) begin b_n[p] <= b_n[p] + 1; b_cyc[p] <= cyc; end
        if (q_awvalid[p] && p_awready[p]) aw_cyc[p] <= cyc;
      end
      if ((s0.awready | s0.wready | s0.bvalid) && (s1.awready | s1.wready | s1.bvalid)) inv_err <= inv_err + 1;
      if ((s0.arready | s0.rvalid) && (s1.arready | s1.rvalid)) inv_err <= inv_err + 1;
      if (wr_st != 2'd1 && (m.awvalid | m.wvalid)) inv_err <= inv_err + 1;
      if (wr_st != 2'd2 && (m.bready | s0.bvalid | s1.bvalid)) inv_err <= inv_err + 1;
      if (rd_st != 2'd1 && m.arvalid) inv_err <= inv_err + 1;
      if (rd_st != 2'd2 && (m.rready | s0.rvalid | s1.rvalid)) inv_err <= inv_err + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
  endtask

  task automatic chk_order(input string name);
    int n;
    chk({name, "_count"}, 64'(w_order.size()), 64'(exp_q.size()));
    n = (w_order.size() < exp_q.size()) ? w_order.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", name, i), 64'(w_order[i]), 64'(exp_q[i]));
    w_order.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic wr(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input int bdly, output logic [1:0] resp);
    logic aw_hs, w_hs, b_hs, done;
    int n;
    q_awaddr[p] = addr; q_wdata[p] = data; q_awvalid[p] = 1; q_wvalid[p] = 1;
    q_bready[p] = (bdly == 0); done = 0; n = 0; resp = 2'bxx;
    while (!done && n < TMO) begin
      @(negedge aclk);
      aw_hs = q_awvalid[p] && p_awready[p];
      w_hs  = q_wvalid[p] && p_wready[p];
      b_hs  = q_bready[p] && p_bvalid[p];
      if (b_hs) resp = p_bresp[p];
      @(posedge aclk); #1;
      n++;
      if (aw_hs) q_awvalid[p] = 0;
      if (w_hs) q_wvalid[p] = 0;
      if (b_hs) begin done = 1; q_bready[p] = 0; end
      else if (n >= bdly) q_bready[p] = 1;
    end
    if (!done) begin
      tmo_fail($sformatf("wr_port%0d_timeout", p));
      q_awvalid[p] = 0; q_wvalid[p] = 0; q_bready[p] = 0;
    end
  endtask

  task automatic rd(input int p, input logic [AW-1:0] addr, input int rdly,
                    output logic [DW-1:0] data, output logic [1:0] resp);
    logic ar_hs, r_hs, done;
    int n;
    q_araddr[p] = addr; q_arvalid[p] = 1; q_rready[p] = (rdly == 0);
    done = 0; n = 0; data = 'x; resp = 2'bxx;
    while (!done && n < TMO) begin
      @(negedge aclk);
      ar_hs = q_arvalid[p] && p_arready[p];
      r_hs  = q_rready[p] && p_rvalid[p];
      if (r_hs) begin data = p_rdata[p]; resp = p_rresp[p]; end
      @(posedge aclk); #1;
      n++;
      if (ar_hs) q_arvalid[p] = 0;
      if (r_hs) begin done = 1; q_rready[p] = 0; end
      else if (n >= rdly) q_rready[p] = 1;
    end
    if (!done) begin
      tmo_fail($sformatf("rd_port%0d_timeout", p));
      q_arvalid[p] = 0; q_rready[p] = 0;
    end
  endtask

  task automatic do_reset();
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;
  endtask

  task automatic wait_wr_state(input logic [1:0] st, input string name);
    int n = 0;
    while (wr_st != st && n < TMO) begin @(negedge aclk); n++; end
    if (wr_st != st) tmo_fail(name);
  endtask

  // each port owns half of the word space: port p uses word indices p*8..p*8+7
  task automatic rand_port(input int p);
    logic [1:0] resp;
    logic [DW-1:0] d;
    int idx;
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      wr(p, AW'((p * 8 + i) * 4), d, $urandom_range(0, 2), resp);
      exp_mem[p * 8 + i] = d;
      chk($sformatf("rand_init_bresp_p%0d", p), 64'(resp), 64'(0));
    end
    for (int i = 0; i < 25; i++) begin
      idx = p * 8 + $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        wr(p, AW'(idx * 4), d, $urandom_range(0, 3), resp);
        exp_mem[idx] = d;
        chk($sformatf("rand_bresp_p%0d", p), 64'(resp), 64'(0));
      end else begin
        rd(p, AW'(idx * 4), $urandom_range(0, 3), d, resp);
        chk($sformatf("rand_rdata_p%0d_w%0d", p, idx), 64'(d), 64'(exp_mem[idx]));
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int            port;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [1:0] resp, resp2;
    logic [DW-1:0] d;
    int s_aw, s_w, s_b0, s_b1;
    bit rand_done;

    for (int p = 0; p < 2; p++) begin
      q_awvalid[p] = 0; q_wvalid[p] = 0; q_bready[p] = 0; q_arvalid[p] = 0; q_rready[p] = 0;
      q_awaddr[p] = 0; q_araddr[p] = 0; q_wdata[p] = 0;
    end
    tbl[0] = '{0, 1, 32'h00, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{0, 0, 32'h00, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1, 1, 32'h20, 32'h000000A5, 32'h0};
    tbl[3] = '{1, 0, 32'h20, 32'h0,        32'h000000A5};
    tbl[4] = '{0, 0, 32'h20, 32'h0,        32'h000000A5};
    tbl[5] = '{1, 1, 32'h04, 32'h5A5A0F0F, 32'h0};
    tbl[6] = '{0, 0, 32'h04, 32'h0,        32'h5A5A0F0F};
    tbl[7] = '{1, 0, 32'h00, 32'h0,        32'hDEADBEEF};

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_valid_ready", 64'({m.awvalid, m.wvalid, m.arvalid, m.bready, m.rready}), 64'(0));
    chk("rst_s_ready_valid", 64'({p_awready, p_wready, p_arready, p_bvalid, p_rvalid}), 64'(0));
    chk("rst_fsm_states", 64'({wr_st, rd_st}), 64'(0));
    chk("rst_data_out", {m.awaddr | m.araddr, m.wdata | s0.rdata | s1.rdata}, 64'(0));
    aresetn = 1;
    @(posedge aclk); #1;

    // table of single transactions
    for (int i = 0; i < 8; i++) begin
      s_b0 = b_n[0]; s_b1 = b_n[1];
      if (tbl[i].is_wr) begin
        wr(tbl[i].port, tbl[i].addr, tbl[i].data, 0, resp);
        exp_q.push_back(tbl[i].data);
        exp_mem[tbl[i].addr[5:2]] = tbl[i].data;
        chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(tbl[i].exp));
        @(negedge aclk);
        chk($sformatf("vec%0d_other_port_b", i),
            64'(tbl[i].port == 0 ? b_n[1] - s_b1 : b_n[0] - s_b0), 64'(0));
      end else begin
        rd(tbl[i].port, tbl[i].addr, 0, d, resp);
        chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(tbl[i].exp));
        chk($sformatf("vec%0d_rresp", i), 64'(resp), 64'(0));
      end
    end
    chk_order("vec_wdata_order");

    // simultaneous writes after reset; port 0 then re-requests at once
    do_reset();
    w_order.delete();
    fork
      begin
        wr(0, 32'h08, 32'h11111111, 0, resp);
        wr(0, 32'h0C, 32'h33333333, 0, resp);
      end
      wr(1, 32'h24, 32'h22222222, 0, resp2);
    join
    exp_mem[2] = 32'h11111111; exp_mem[3] = 32'h33333333; exp_mem[9] = 32'h22222222;
    exp_q.push_back(32'h11111111);
`ifdef AXIL_ARB_FIXED_PRIO_EN
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h22222222);
`else
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
`endif
    chk_order("tie_order");

    // concurrent write on port 1 and read on port 0
    fork
      wr(1, 32'h28, 32'h000000A5, 0, resp);
      rd(0, 32'h00, 0, d, resp2);
    join
    exp_mem[10] = 32'h000000A5;
    chk("conc_wr_bresp", 64'(resp), 64'(0));
    chk("conc_rd_rdata", 64'(d), 64'(32'hDEADBEEF));
    rd(0, 32'h28, 0, d, resp);
    chk("conc_later_rdata", 64'(d), 64'(32'h000000A5));

    // AW ready three cycles later than W ready
    aw_dly = 3; w_dly = 0;
    @(negedge aclk);
    s_aw = m_aw_n; s_w = m_w_n; s_b0 = b_n[0];
    wr(0, 32'h10, 32'h0BADF00D, 0, resp);
    exp_mem[4] = 32'h0BADF00D;
    @(negedge aclk);
    chk("skew_aw_count", 64'(m_aw_n - s_aw), 64'(1));
    chk("skew_w_count", 64'(m_w_n - s_w), 64'(1));
    chk("skew_b_count", 64'(b_n[0] - s_b0), 64'(1));
    chk("skew_bresp", 64'(resp), 64'(0));
    aw_dly = 0;

    // port 0 stalls its B while port 1 asks
    fork
      wr(0, 32'h14, 32'h44444444, 14, resp);
      begin
        wait_wr_state(2'd2, "stall_wait_resp");
        @(posedge aclk); #1;
        wr(1, 32'h2C, 32'h55555555, 0, resp2);
      end
    join
    exp_mem[5] = 32'h44444444; exp_mem[11] = 32'h55555555;
    chk("stall_s1_after_s0_b", 64'(aw_cyc[1] > b_cyc[0]), 64'(1));
    chk("stall_s1_bresp", 64'(resp2), 64'(0));

    // reset while the write waits for its response
    begin
      logic aw_hs, w_hs;
      int n = 0;
      q_awaddr[0] = 32'h18; q_wdata[0] = 32'h66666666; q_awvalid[0] = 1; q_wvalid[0] = 1; q_bready[0] = 0;
      while (!(wr_st == 2'd2 && m.bvalid) && n < TMO) begin
        @(negedge aclk);
        aw_hs = q_awvalid[0] && p_awready[0];
        w_hs  = q_wvalid[0] && p_wready[0];
        if (!(wr_st == 2'd2 && m.bvalid)) begin
          @(posedge aclk); #1;
          if (aw_hs) q_awvalid[0] = 0;
          if (w_hs) q_wvalid[0] = 0;
        end
        n++;
      end
      if (n >= TMO) tmo_fail("rst_mid_wait_resp");
      q_awvalid[0] = 0; q_wvalid[0] = 0;
      exp_mem[6] = 32'h66666666;
      aresetn = 0;
      #1;
      chk("rst_mid_fsm_idle", 64'({wr_st, rd_st}), 64'(0));
      chk("rst_mid_s_outputs", 64'({p_awready, p_wready, p_arready, p_bvalid, p_rvalid}), 64'(0));
      chk("rst_mid_m_outputs", 64'({m.awvalid, m.wvalid, m.arvalid, m.bready, m.rready}), 64'(0));
      chk("rst_mid_bresp", 64'({p_bresp[0], p_bresp[1]}), 64'(0));
      q_bready[0] = 1;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1;
      s_b0 = b_n[0];
      repeat (8) @(posedge aclk);
      @(negedge aclk);
      chk("rst_mid_no_stale_b", 64'(b_n[0] - s_b0), 64'(0));
      chk("rst_mid_wr_idle", 64'(wr_st), 64'(0));
      q_bready[0] = 0;
    end

    // randomized traffic from both ports with varying slave delays
    rand_done = 0;
    fork
      begin
        fork
          rand_port(0);
          rand_port(1);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge aclk);
          aw_dly = $urandom_range(0, 3);
          w_dly  = $urandom_range(0, 3);
          ar_dly = $urandom_range(0, 3);
        end
      end
    join

    @(negedge aclk);
    chk("channel_invariants", 64'(inv_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/axil_arbiter_2x1.md
AXIL_ARBITER_2X1 -- requirements
Module: axil_arbiter_2x1

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data bus width of all AXI-Lite ports.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning address bus width of all AXI-Lite ports.
REQ-003 SHALL have port aclk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s0_axil  axil_if.s_axil  -  requester 0, AXI-Lite slave side.
REQ-006 SHALL have port s1_axil  axil_if.s_axil  -  requester 1, AXI-Lite slave side.
REQ-007 SHALL have port m_axil  axil_if.m_axil  -  shared downstream AXI-Lite slave (e.g. axil_slave GPIO register).

Function
REQ-008 SHALL contain two independent arbiters, write (AW/W/B) and read (AR/R), each owning m_axil's matching channels.
REQ-009 Write request from port n SHALL be sn.awvalid & sn.wvalid; read request SHALL be sn.arvalid.
REQ-010 Write FSM states SHALL be WR_IDLE, WR_ADDR, WR_RESP; read FSM states SHALL be RD_IDLE, RD_ADDR, RD_RESP.
REQ-011 In *_IDLE with any request, the FSM SHALL register grant and enter *_ADDR next cycle (one cycle arbitration latency); with no request it SHALL stay.
REQ-012 If both ports request in the same cycle, grant SHALL go to the port not granted last on that channel (round-robin); a single requester SHALL be granted immediately.
REQ-013 In WR_ADDR, AW and W of the granted port SHALL be forwarded combinationally to m_axil (valid, addr, data, strb forward; ready returns).
REQ-014 WR_ADDR SHALL track aw_done and w_done separately, SHALL deassert forwarded valid of a completed channel, and SHALL enter WR_RESP once both completed (same cycle or different cycles).
REQ-015 In RD_ADDR, AR SHALL be forwarded likewise; on m_axil.arvalid & m_axil.arready the FSM SHALL enter RD_RESP.
REQ-016 In *_RESP, bvalid/bresp (rvalid/rdata/rresp) SHALL route to the granted port only, bready (rready) from the granted port only.
REQ-017 On response handshake the FSM SHALL return to *_IDLE and update the last-grant pointer to the granted port.
REQ-018 The ungranted port, and both ports in *_IDLE, SHALL see awready, wready, arready, bvalid, rvalid all 0.
REQ-019 m_axil valids SHALL be 0 in *_IDLE and *_RESP; m_axil bready/rready SHALL be 0 outside *_RESP.
REQ-020 Grant SHALL not change between *_ADDR entry and response handshake, regardless of requester activity.
REQ-021 Write and read transactions SHALL proceed concurrently, on same or different ports.

Reset
REQ-022 aresetn low SHALL immediately force both FSMs to *_IDLE, aw_done/w_done to 0, and last-grant pointers to port 1 (port 0 wins first tie).
REQ-023 During reset all valid and ready outputs on all three ports SHALL be 0; data/resp outputs SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no response delivered after release.

Configuration
REQ-025 Macro AXIL_ARB_FIXED_PRIO_EN defined SHALL make both arbiters fixed-priority, port 0 always winning ties; last-grant pointers SHALL not be implemented.
REQ-026 Macro AXIL_ARB_FIXED_PRIO_EN undefined SHALL give round-robin per REQ-012.

Verification
REQ-027 s0 writes 0xDEADBEEF alone -> m_axil sees one write of 0xDEADBEEF, s0 gets bresp 2'b00, s1 ready/bvalid stay 0.
REQ-028 s0 and s1 assert writes (0x11111111, 0x22222222) same cycle after reset -> s0 served first, s1 second; then repeat -> s1 first (round-robin), or s0 first with AXIL_ARB_FIXED_PRIO_EN.
REQ-029 s1 write of 0x000000A5 concurrent with s0 read -> both complete; later s0 read returns 0x000000A5.
REQ-030 Downstream holds awready 0 three cycles longer than wready -> single AW and single W handshake, exactly one B to requester.
REQ-031 s0 holds bready 0 for 10 cycles during WR_RESP while s1 requests -> s1 not granted until s0 B handshake.
REQ-032 aresetn pulsed low in WR_RESP -> all valids/readys 0 same cycle, FSM idle, no stale bvalid after release.
